// File: rtl/vp_pkg.sv
// Shared constants and FSM encoding for the vector processor load path.
package vp_pkg;

    localparam int ELEM_W = 16;
    localparam int LANES  = 4;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vec_lane_pack.sv
// Lane-insert register: gathers elements lane by lane into a 64-bit word and
// emits it with a one-cycle strobe when the top lane or the final element
// arrives. The gathering register is cleared after every strobe so a partial
// final word carries zeros in its unused upper lanes.
module vec_lane_pack #(
    parameter int ELEM_W = vp_pkg::ELEM_W,
    parameter int LANES  = vp_pkg::LANES,
    parameter int LANE_W = $clog2(vp_pkg::LANES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic [ELEM_W-1:0]         elem,
    input  logic [LANE_W-1:0]         lane,
    input  logic                      last,
    output logic [ELEM_W*LANES-1:0]   word,
    output logic                      strobe
);

    logic [ELEM_W*LANES-1:0] acc;
    logic [ELEM_W*LANES-1:0] acc_ins;
    logic                    flush;

    // Merge the incoming element into its lane and decide whether the word is complete.
    always_comb begin
        acc_ins = acc;
        acc_ins[ELEM_W*lane +: ELEM_W] = elem;
        flush = valid && ((lane == LANE_W'(LANES - 1)) || last);
    end

    // Gathering register, output word and strobe; word holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            word   <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= flush;
            if (flush) begin
                word <= acc_ins;
                acc  <= '0;
            end else if (valid) begin
                acc <= acc_ins;
            end
        end
    end

endmodule

// File: rtl/vec_load_pack.sv
// Vector load stage: streams vlen elements from a 1-cycle-latency BRAM
// starting at base_addr and packs LANES of them into each 64-bit word for
// the downstream operand register.
// Handshake: start is a request sampled only while busy=0 (IDLE or the done
// cycle); wea is a one-cycle strobe with no back-pressure, dataout and
// word_idx are meaningful while wea=1.
module vec_load_pack #(
    parameter int ADDR_W = 8,
    parameter int ELEM_W = vp_pkg::ELEM_W,
    parameter int LANES  = vp_pkg::LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       vlen,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [ELEM_W-1:0]       mem_dout,
    output logic [63:0]             dataout,
    output logic                    wea,
    output logic [ADDR_W-1:0]       word_idx,
    output logic                    busy,
    output logic                    done
);

    import vp_pkg::*;

    localparam int LANE_W = $clog2(LANES);

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic [ADDR_W-1:0]   vlen_q;
    logic [ADDR_W-1:0]   issue_idx;
    logic                issue_last;

    // Element index, last flag and valid bit travelling alongside the BRAM read.
    logic                v1;
    logic [ADDR_W-1:0]   idx1;
    logic                last1;
    logic [LANE_W-1:0]   lane1;

    assign lane1 = idx1[LANE_W-1:0];

    // Launch acceptance and end-of-issue detection.
    always_comb begin
        accept     = start && ((state_q == IDLE) || (state_q == DONE));
        issue_last = (issue_idx == (vlen_q - ADDR_W'(1)));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (accept) begin
                    state_d = (vlen == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // The last read's data has been captured once the pipe is empty.
                if (!v1) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read issue: one address per cycle from base_addr, wrapping modulo 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            issue_idx <= '0;
            vlen_q    <= '0;
        end else if (accept) begin
            mem_en    <= (vlen != '0);
            mem_addr  <= base_addr;
            issue_idx <= '0;
            vlen_q    <= vlen;
        end else if (state_q == RUN) begin
            if (issue_last) begin
                mem_en <= 1'b0;
            end else begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                issue_idx <= issue_idx + ADDR_W'(1);
            end
        end
    end

    // Valid pipe aligned with mem_dout, plus the word index of each strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1       <= 1'b0;
            idx1     <= '0;
            last1    <= 1'b0;
            word_idx <= '0;
        end else begin
            v1    <= mem_en;
            idx1  <= issue_idx;
            last1 <= issue_last;
            if (v1 && ((lane1 == LANE_W'(LANES - 1)) || last1)) begin
                word_idx <= idx1 >> LANE_W;
            end
        end
    end

    vec_lane_pack #(
        .ELEM_W (ELEM_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_pack (
        .clk    (clk),
        .rst    (rst),
        .valid  (v1),
        .elem   (mem_dout),
        .lane   (lane1),
        .last   (last1),
        .word   (dataout),
        .strobe (wea)
    );

endmodule

// File: tb/tb_vec_load_pack.sv
// Directed and randomized checks of vec_load_pack against a cycle-level
// reference computed from the element stream arithmetic.
module tb_vec_load_pack;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  vlen;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout;
    logic [63:0] dataout;
    logic        wea;
    logic [7:0]  word_idx;
    logic        busy;
    logic        done;

    int          errors;
    int          checks;
    logic [63:0] exp_hold;

    vec_load_pack #(.ADDR_W(8), .ELEM_W(16), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .vlen      (vlen),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .dataout   (dataout),
        .wea       (wea),
        .word_idx  (word_idx),
        .busy      (busy),
        .done      (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: mem[a] = 16'h1000 + a, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= 16'h1000 + {8'h00, mem_addr};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference word g of an operation: element e sits in lane e%4 and holds
    // 16'h1000 + ((base+e) mod 256); lanes past the end of the vector are zero.
    function automatic logic [63:0] exp_word(input logic [7:0] b, input int n, input int g);
        logic [63:0] w;
        logic [7:0]  a;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            if (g * 4 + j < n) begin
                a = b + 8'(g * 4 + j);
                w = w | ({48'h0, 16'h1000 + {8'h00, a}} << (16 * j));
            end
        end
        return w;
    endfunction

    // Run one operation, checking every cycle from cycle 0 to the done cycle.
    // Called at a falling edge. poke>=0 raises a stray start in that cycle.
    task automatic run_op(input logic [7:0] b, input int n, input bit do_launch,
                          input bit chain, input logic [7:0] cb, input int cn,
                          input int poke);
        int last_c;
        int k;
        bit wea_e;
        if (do_launch) begin
            start = 1'b1; base_addr = b; vlen = n[7:0];
        end
        last_c = (n == 0) ? 0 : n + 2;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            @(negedge clk);
            k = c - 2;
            wea_e = (k >= 0) && (k < n) && ((k % 4 == 3) || (k == n - 1));
            if (wea_e) exp_hold = exp_word(b, n, k / 4);
            chk("mem_en", {63'h0, mem_en}, {63'h0, c < n});
            if (c < n) chk("mem_addr", {56'h0, mem_addr}, {56'h0, b + 8'(c)});
            chk("wea", {63'h0, wea}, {63'h0, wea_e});
            chk("dataout", dataout, exp_hold);
            if (wea_e) chk("word_idx", {56'h0, word_idx}, 64'(k / 4));
            chk("busy", {63'h0, busy}, {63'h0, (n > 0) && (c <= n + 1)});
            chk("done", {63'h0, done}, {63'h0, c == last_c});
            if (c == 0) start = 1'b0;
            if (c == poke) begin
                start = 1'b1;
                base_addr = 8'($urandom_range(0, 255));
                vlen = 8'($urandom_range(1, 20));
            end
            if (c == poke + 1) start = 1'b0;
            if (c == last_c && chain) begin
                start = 1'b1; base_addr = cb; vlen = cn[7:0];
            end
        end
    endtask

    // Idle cycles: nothing may move without a start.
    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", {63'h0, busy}, 64'h0);
            chk("idle_done", {63'h0, done}, 64'h0);
            chk("idle_wea", {63'h0, wea}, 64'h0);
            chk("idle_mem_en", {63'h0, mem_en}, 64'h0);
            chk("idle_dataout", dataout, exp_hold);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dataout"}, dataout, 64'h0);
        chk({tag, "_wea"}, {63'h0, wea}, 64'h0);
        chk({tag, "_word_idx"}, {56'h0, word_idx}, 64'h0);
        chk({tag, "_mem_en"}, {63'h0, mem_en}, 64'h0);
        chk({tag, "_mem_addr"}, {56'h0, mem_addr}, 64'h0);
        chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
        chk({tag, "_done"}, {63'h0, done}, 64'h0);
    endtask

    logic [7:0] rb[8];
    int         rn[8];

    initial begin
        errors = 0; checks = 0; exp_hold = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; vlen = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        idle_check(2);

        // Directed cases from the plan.
        run_op(8'h10, 4, 1, 0, 8'h0, 0, -1);
        chk("tp1_word", exp_hold, 64'h1013_1012_1011_1010);
        idle_check(1);
        run_op(8'h00, 6, 1, 0, 8'h0, 0, -1);
        chk("tp2_word", exp_hold, 64'h0000_0000_1005_1004);
        run_op(8'hFE, 4, 1, 0, 8'h0, 0, -1);
        chk("tp3_wrap", exp_hold, 64'h1001_1000_10FF_10FE);
        idle_check(1);
        run_op(8'h55, 0, 1, 0, 8'h0, 0, -1);
        idle_check(2);

        // Stray start while busy must be ignored.
        run_op(8'h00, 8, 1, 0, 8'h0, 0, 2);
        idle_check(2);

        // Asynchronous reset in cycle 3 of a fresh run.
        start = 1'b1; base_addr = 8'h00; vlen = 8'd8;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        exp_hold = '0;
        @(negedge clk);
        rst = 1'b0;
        idle_check(4);
        run_op(8'h20, 4, 1, 0, 8'h0, 0, -1);
        chk("post_rst_word", exp_hold, 64'h1023_1022_1021_1020);

        // Back-to-back launch in the done cycle.
        run_op(8'h30, 4, 1, 1, 8'h40, 4, -1);
        run_op(8'h40, 4, 0, 0, 8'h0, 0, -1);
        idle_check(1);

        // Randomized chained operations, including vlen=0 and partial words.
        for (int i = 0; i < 8; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            rn[i] = $urandom_range(0, 13);
        end
        for (int i = 0; i < 8; i++) begin
            run_op(rb[i], rn[i], i == 0, i < 7, (i < 7) ? rb[(i + 1) % 8] : 8'h0,
                   (i < 7) ? rn[(i + 1) % 8] : 0, -1);
        end
        idle_check(2);

        // Full-length vector wrapping through the whole address space.
        run_op(8'($urandom_range(0, 255)), 255, 1, 0, 8'h0, 0, -1);
        idle_check(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
